// File: rtl/data_sram_resp_if.sv
// Execute-stage data SRAM port: request from the pipeline, read data and status back from the memory.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic        data_sram_err;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, data_sram_rvalid, data_sram_err
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, data_sram_rvalid, data_sram_err
    );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-writable word memory with fixed read latency and address-range checking.
// Define DATA_SRAM_ERR_EN to enable the out-of-range error pulse on data_sram_err.
module data_sram_resp #(
    parameter int unsigned DEPTH     = 65536,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input logic             clk,
    input logic             reset,
    data_sram_resp_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $fatal(1, "data_sram_resp: LATENCY must be in 1..4");
    end
    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "data_sram_resp: DEPTH must be a power of two, at least 16");
    end
    if ((33'(ADDR_BASE) % SPAN) != 33'd0) begin : g_bad_base
        $fatal(1, "data_sram_resp: ADDR_BASE must be aligned to DEPTH*4");
    end

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             req_rd;
    logic             req_wr;
    logic [31:0]      req_word;
    logic [31:0]      mem [DEPTH];

    // Wrapping subtraction: with an aligned base, in range iff the offset is below the span.
    assign offset   = bus.data_sram_addr - ADDR_BASE;
    assign in_range = (33'(offset) < SPAN);
    assign idx      = offset[IDX_W+1:2];
    assign req_rd   = bus.data_sram_en && (bus.data_sram_wen == 4'h0);
    assign req_wr   = bus.data_sram_en && (bus.data_sram_wen != 4'h0) && in_range;
    assign req_word = in_range ? mem[idx] : 32'h0;

    // Byte-lane writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (req_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    logic        fin_v;
    logic [31:0] fin_d;
`ifdef DATA_SRAM_ERR_EN
    logic        fin_e;
`endif

    // The sampled word rides LATENCY-1 extra stages before the output register.
    if (LATENCY > 1) begin : g_pipe
        localparam int unsigned N  = LATENCY - 1;
        localparam int unsigned DW = 32 * N;
        logic [N-1:0]       v_q;
        logic [N-1:0][31:0] d_q;
`ifdef DATA_SRAM_ERR_EN
        logic [N-1:0]       e_q;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= '0;
            end else begin
                v_q <= N'({v_q, req_rd});
            end
            d_q <= DW'({d_q, req_word});
        end

`ifdef DATA_SRAM_ERR_EN
        always_ff @(posedge clk) begin
            if (reset) begin
                e_q <= '0;
            end else begin
                e_q <= N'({e_q, req_rd && !in_range});
            end
        end
        assign fin_e = e_q[N-1];
`endif
        assign fin_v = v_q[N-1];
        assign fin_d = d_q[N-1];
    end else begin : g_direct
        assign fin_v = req_rd;
        assign fin_d = req_word;
`ifdef DATA_SRAM_ERR_EN
        assign fin_e = !in_range;
`endif
    end

    logic [31:0] rdata_q;
    logic        rvalid_q;

    // rdata holds the last delivered word until the next delivery or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= fin_v;
            if (fin_v) begin
                rdata_q <= fin_d;
            end
        end
    end

    assign bus.data_sram_rdata  = rdata_q;
    assign bus.data_sram_rvalid = rvalid_q;

`ifdef DATA_SRAM_ERR_EN
    logic err_q;

    // Read errors arrive with rvalid; write errors one cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (fin_v && fin_e)
                   || (bus.data_sram_en && (bus.data_sram_wen != 4'h0) && !in_range);
        end
    end
    assign bus.data_sram_err = err_q;
`else
    assign bus.data_sram_err = 1'b0;
`endif
endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: four instances (LATENCY 1..4, the last with DEPTH=16) share one stimulus
// stream; a scoreboard of expected deliveries is checked every cycle on the falling edge.
module tb_data_sram_resp;
`ifdef DATA_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          dut;
        int          cyc;
        bit          rd;
        logic [31:0] data;
        bit          err;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_on = 1'b0;
    sb_t sbq[$];

    logic [31:0] model [4][64];
    logic [31:0] rd_a [4];
    logic        rv_a [4];
    logic        er_a [4];

    data_sram_resp_if bus_l1 ();
    data_sram_resp_if bus_l2 ();
    data_sram_resp_if bus_l3 ();
    data_sram_resp_if bus_l4 ();

    assign bus_l1.data_sram_en = en;  assign bus_l1.data_sram_wen = wen;
    assign bus_l1.data_sram_addr = addr;  assign bus_l1.data_sram_wdata = wdata;
    assign bus_l2.data_sram_en = en;  assign bus_l2.data_sram_wen = wen;
    assign bus_l2.data_sram_addr = addr;  assign bus_l2.data_sram_wdata = wdata;
    assign bus_l3.data_sram_en = en;  assign bus_l3.data_sram_wen = wen;
    assign bus_l3.data_sram_addr = addr;  assign bus_l3.data_sram_wdata = wdata;
    assign bus_l4.data_sram_en = en;  assign bus_l4.data_sram_wen = wen;
    assign bus_l4.data_sram_addr = addr;  assign bus_l4.data_sram_wdata = wdata;

    assign rd_a[0] = bus_l1.data_sram_rdata;  assign rv_a[0] = bus_l1.data_sram_rvalid;
    assign rd_a[1] = bus_l2.data_sram_rdata;  assign rv_a[1] = bus_l2.data_sram_rvalid;
    assign rd_a[2] = bus_l3.data_sram_rdata;  assign rv_a[2] = bus_l3.data_sram_rvalid;
    assign rd_a[3] = bus_l4.data_sram_rdata;  assign rv_a[3] = bus_l4.data_sram_rvalid;
    assign er_a[0] = bus_l1.data_sram_err;    assign er_a[1] = bus_l2.data_sram_err;
    assign er_a[2] = bus_l3.data_sram_err;    assign er_a[3] = bus_l4.data_sram_err;

    data_sram_resp #(.DEPTH(64), .ADDR_BASE(32'h0), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(bus_l1.slave));
    data_sram_resp #(.DEPTH(64), .ADDR_BASE(32'h0), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(bus_l2.slave));
    data_sram_resp #(.DEPTH(64), .ADDR_BASE(32'h0), .LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(bus_l3.slave));
    data_sram_resp #(.DEPTH(16), .ADDR_BASE(32'h0), .LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(bus_l4.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 3) ? 16 : 64;
    endfunction

    // Scoreboard: every due entry is popped and compared; no entry due means no rvalid and no err.
    always @(negedge clk) begin
        logic        ev;
        logic        ee;
        logic [31:0] ed;
        if (mon_on) begin
            for (int k = 0; k < 4; k++) begin
                ev = 1'b0;
                ee = 1'b0;
                ed = 32'h0;
                for (int j = sbq.size() - 1; j >= 0; j--) begin
                    if (sbq[j].dut == k && sbq[j].cyc == cyc) begin
                        if (sbq[j].rd) begin
                            ev = 1'b1;
                            ed = sbq[j].data;
                        end
                        ee = ee | sbq[j].err;
                        sbq.delete(j);
                    end
                end
                checks++;
                if (rv_a[k] !== ev || er_a[k] !== ee || (ev && rd_a[k] !== ed)) begin
                    errors++;
                    $display("FAIL sb_lat%0d cyc=%0d: rvalid=%b err=%b rdata=%h, expected rvalid=%b err=%b rdata=%h",
                             lat_of(k), cyc, rv_a[k], er_a[k], rd_a[k], ev, ee, ed);
                end
            end
        end
    end

    task automatic idle(input int n);
        en    = 1'b0;
        wen   = 4'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        repeat (n) @(negedge clk);
    endtask

    // One request cycle; the bench model and scoreboard are updated as it is driven.
    task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        sb_t e;
        int  idx;
        bit  oor;
        en    = 1'b1;
        wen   = w;
        addr  = a;
        wdata = d;
        for (int k = 0; k < 4; k++) begin
            oor = (a >= 32'(depth_of(k) * 4));
            idx = int'((a >> 2) & 32'(depth_of(k) - 1));
            if (w == 4'h0) begin
                e.dut  = k;
                e.cyc  = cyc + lat_of(k);
                e.rd   = 1'b1;
                e.data = oor ? 32'h0 : model[k][idx];
                e.err  = ERR_EN && oor;
                sbq.push_back(e);
            end else if (oor) begin
                if (ERR_EN) begin
                    e.dut  = k;
                    e.cyc  = cyc + 1;
                    e.rd   = 1'b0;
                    e.data = 32'h0;
                    e.err  = 1'b1;
                    sbq.push_back(e);
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (w[b]) model[k][idx][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 32'h0 || rv_a[k] !== 1'b0 || er_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_lat%0d: rdata=%h rvalid=%b err=%b, expected 0 0 0", lat_of(k), rd_a[k], rv_a[k], er_a[k]);
            end
        end
        mon_on = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle(1);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rd_a[k] !== 32'h0 || rv_a[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_lat%0d: rdata=%h rvalid=%b, expected 0 0", lat_of(k), rd_a[k], rv_a[k]);
                end
            end
        end
    endtask

    task automatic test_byte_writes();
        issue(32'h10, 4'hf, 32'h1122_3344);
        issue(32'h10, 4'h2, 32'hAAAA_AAAA);
        issue(32'h10, 4'hc, 32'hBBBB_BBBB);
        issue(32'h10, 4'h0, 32'h0);
        idle(6);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 32'hBBBB_AA44) begin
                errors++;
                $display("FAIL byte_merge_lat%0d: rdata=%h, expected bbbbaa44", lat_of(k), rd_a[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) issue(32'(i * 4), 4'hf, 32'(i + 1));
        for (int i = 0; i < 4; i++) issue(32'(i * 4), 4'h0, 32'h0);
        idle(8);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 32'd4) begin
                errors++;
                $display("FAIL b2b_hold_lat%0d: rdata=%h, expected 00000004", lat_of(k), rd_a[k]);
            end
        end
    endtask

    task automatic test_write_then_read();
        issue(32'h40, 4'hf, 32'hDEAD_BEEF);
        issue(32'h40, 4'h0, 32'h0);
        idle(6);
        checks++;
        if (rd_a[1] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wtr_lat2: rdata=%h, expected deadbeef", rd_a[1]);
        end
    endtask

    task automatic test_out_of_range();
        issue(32'h40, 4'hf, 32'h1234_5678);
        issue(32'h00, 4'h0, 32'h0);
        issue(32'h40, 4'h0, 32'h0);
        idle(6);
        checks++;
        if (rd_a[3] !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_depth16: rdata=%h, expected 00000000", rd_a[3]);
        end
        checks++;
        if (rd_a[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL inrange_read_lat1: rdata=%h, expected 12345678", rd_a[0]);
        end
    endtask

    task automatic test_reset_mid_flight();
        issue(32'h08, 4'h0, 32'h0);
        idle(1);
        reset = 1'b1;
        for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].cyc > cyc) sbq.delete(j);
        end
        idle(1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 32'h0 || rv_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_lat%0d: rdata=%h rvalid=%b, expected 0 0", lat_of(k), rd_a[k], rv_a[k]);
            end
        end
        idle(6);
        issue(32'h10, 4'h0, 32'h0);
        idle(6);
        checks++;
        if (rd_a[3] !== 32'hBBBB_AA44) begin
            errors++;
            $display("FAIL persist_lat4: rdata=%h, expected bbbbaa44", rd_a[3]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) issue(32'(i * 4), 4'hf, $urandom);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 1) == 0) issue(32'($urandom_range(0, 127)), 4'h0, $urandom);
            else issue(32'($urandom_range(0, 127)), 4'($urandom_range(1, 15)), $urandom);
        end
        idle(8);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        wen   = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        test_reset();
        test_byte_writes();
        test_back_to_back();
        test_write_then_read();
        test_out_of_range();
        test_reset_mid_flight();
        test_random();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the execute-stage data SRAM port (en/wen/addr/wdata).
- Word-organised, byte-writable synchronous memory with a configurable fixed read latency and address-range checking.
- Drives read data back to the memory stage.
- Used as the data-side memory in core-level simulation, and as the reference responder when EXE/MEM timing is changed.

Parameters:
DEPTH, 65536, number of 32-bit words; power of two, minimum 16
ADDR_BASE, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned
LATENCY, 1, cycles from accepted read to data_sram_rdata/rvalid; legal 1..4

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
data_sram_en  input  1  access request this cycle
data_sram_wen  input  4  byte write enables; 4'h0 = read
data_sram_addr  input  32  byte address; bits [1:0] ignored
data_sram_wdata  input  32  write data, lane-replicated by requester
data_sram_rdata  output  32  read data
data_sram_rvalid  output  1  one-cycle pulse, rdata valid for a read
data_sram_err  output  1  out-of-range pulse, aligned with rvalid/commit (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high, named reset.
- Reset values: data_sram_rdata=0, data_sram_rvalid=0, data_sram_err=0, all latency-pipeline valid bits cleared. Memory array is not reset.
- Handshake: none. Every cycle with data_sram_en=1 is accepted; one access per cycle, fully pipelined, no stalls.
- In range: addr in [ADDR_BASE, ADDR_BASE+DEPTH*4). Index = (addr-ADDR_BASE)>>2, truncated to log2(DEPTH) bits.
- Write (en=1, wen!=0, in range):
  - Each lane i with wen[i]=1 gets wdata[8i+7:8i] at the clock edge ending the request cycle.
  - Other lanes are unchanged.
  - No rvalid pulse; rdata holds its previous value.
- Read (en=1, wen=0):
  - Word is sampled at the request edge and delivered after LATENCY edges.
  - LATENCY=1: rdata/rvalid change at the edge ending the request cycle, so they are visible in the following cycle. This matches the existing MEM-stage expectation.
  - LATENCY>1: the sampled word passes through LATENCY-1 extra register stages, each carrying a valid bit.
- rdata hold: rdata holds the last delivered read value until the next rvalid; it is never cleared except by reset.
- Write-then-read: a read to the same word in the cycle after a write returns the new data for all LATENCY values.
- Out of range:
  - Writes are dropped; memory is unchanged.
  - Reads deliver rdata=32'h0 with rvalid=1 at normal latency.
- en=0: inputs ignored; no state change.
- Reset mid-operation: in-flight reads are discarded and no rvalid appears after reset deasserts. Writes committed before reset persist.
- Parameter checks: LATENCY outside 1..4, or ADDR_BASE misaligned, is a simulation-time fatal error.

Optional Feature:
- Macro: DATA_SRAM_ERR_EN.
- Defined:
  - data_sram_err pulses 1 for one cycle for any out-of-range access.
  - Reads: the pulse is coincident with that access's rvalid.
  - Writes: the pulse is in the cycle after the request.
  - An err bit is carried in the latency pipeline.
- Undefined: data_sram_err is tied to 0; no err pipeline logic.

Test Plan:
- Reset then idle: reset high 2 cycles, then low -> rdata=0, rvalid=0, err=0 held while en=0.
- Byte and half writes: write word 32'h1122_3344 wen=4'hf at 0x10, then wen=4'h2 wdata=32'hAAAA_AAAA, then wen=4'hc wdata=32'hBBBB_BBBB, then read 0x10 -> rdata=32'hBBBB_AA44, rvalid one cycle after read (LATENCY=1).
- Back-to-back reads, LATENCY=3: words 0x0..0xC preloaded with 1,2,3,4; reads issued on consecutive cycles -> rvalid high 4 consecutive cycles starting 3 cycles after the first read, rdata 1,2,3,4; rdata holds 4 afterwards.
- Write-then-read, LATENCY=2: write 32'hDEAD_BEEF to 0x40 at cycle n, read 0x40 at n+1 -> rdata=32'hDEAD_BEEF, rvalid at cycle n+3.
- Out-of-range with DATA_SRAM_ERR_EN, DEPTH=16, ADDR_BASE=0:
  - write to 0x40 -> memory unchanged, err pulse the next cycle.
  - read 0x40 -> rdata=0, rvalid=1 and err=1 in the same cycle.
  - Without the macro: err stays 0 throughout.
- Reset mid-flight, LATENCY=4: read issued, reset asserted 2 cycles later for 1 cycle -> no rvalid ever appears; a subsequent read of a previously written word returns the written value.
